// File: rtl/traffic_display_driver.sv
// rtl/traffic_display_driver.sv - traffic lamp decode with blinking override and a 2-digit multiplexed countdown display
//   clk         : single clock
//   reset       : asynchronous active-low reset
//   phase       : 00 off/yellow, 01 left, 10 forward, 11 right
//   count       : remaining seconds of the current phase
//   switch      : manual-off request (flashing yellow)
//   lamp_green  : green lamp
//   lamp_yellow : yellow lamp
//   arrow       : {left, forward, right} arrows
//   seg         : segments {g..a}, active-high
//   dig         : one-hot digit enables, bit0 ones, bit1 tens
//   sat         : displayed value clipped at 99
//   busy        : BCD conversion in progress
module traffic_display_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  phase,
  input  logic [31:0] count,
  input  logic        switch,
  output logic        lamp_green,
  output logic        lamp_yellow,
  output logic [2:0]  arrow,
  output logic [6:0]  seg,
  output logic [1:0]  dig,
  output logic        sat,
  output logic        busy
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [31:0]   count_q, count_d;
  logic          sw_q, sw_d;
  logic          green_q, green_d;
  logic          yellow_q, yellow_d;
  logic [2:0]    arrow_q, arrow_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          sat_q, sat_d;
  // {tens, ones, binary} working register for double-dabble
  logic [14:0]   sr_q, sr_d;
  logic [2:0]    shift_cnt_q, shift_cnt_d;
  logic [31:0]   conv_src_q, conv_src_d;
  logic          conv_sat_q, conv_sat_d;
  logic [31:0]   last_conv_q, last_conv_d;
  logic          pending_q, pending_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          dig_sel_q, dig_sel_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  logic [6:0]    conv_val;
  logic [3:0]    tens_adj, ones_adj;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h3F;
      4'd1:    seg_enc = 7'h06;
      4'd2:    seg_enc = 7'h5B;
      4'd3:    seg_enc = 7'h4F;
      4'd4:    seg_enc = 7'h66;
      4'd5:    seg_enc = 7'h6D;
      4'd6:    seg_enc = 7'h7D;
      4'd7:    seg_enc = 7'h07;
      4'd8:    seg_enc = 7'h7F;
      4'd9:    seg_enc = 7'h6F;
      default: seg_enc = 7'h00;
    endcase
  endfunction

  always_comb begin
    phase_d     = phase;
    count_d     = count;
    sw_d        = switch;
    state_d     = state_q;
    sr_d        = sr_q;
    shift_cnt_d = shift_cnt_q;
    conv_src_d  = conv_src_q;
    conv_sat_d  = conv_sat_q;
    last_conv_d = last_conv_q;
    pending_d   = pending_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    sat_d       = sat_q;
    tens_adj    = sr_q[14:11];
    ones_adj    = sr_q[10:7];
    conv_val    = (count_q > 32'd99) ? 7'd99 : count_q[6:0];

    case (state_q)
      S_IDLE: begin
        if ((count_q != last_conv_q) || pending_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        sr_d        = {8'd0, conv_val};
        conv_src_d  = count_q;
        conv_sat_d  = (count_q > 32'd99);
        pending_d   = 1'b0;
        shift_cnt_d = 3'd0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        if (tens_adj >= 4'd5) tens_adj = tens_adj + 4'd3;
        if (ones_adj >= 4'd5) ones_adj = ones_adj + 4'd3;
        sr_d = {tens_adj, ones_adj, sr_q[6:0]} << 1;
        if (shift_cnt_q == 3'd6) state_d = S_DONE;
        else shift_cnt_d = shift_cnt_q + 3'd1;
        if (count_q != conv_src_q) pending_d = 1'b1;
      end
      S_DONE: begin
        // digits, saturation flag and last_conv all move together
        tens_d      = sr_q[14:11];
        ones_d      = sr_q[10:7];
        sat_d       = conv_sat_q;
        last_conv_d = conv_src_q;
        if (count_q != conv_src_q) pending_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // digit scan
    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SW'(1);
    dig_sel_d  = dig_sel_q ^ (scan_cnt_q == SCAN_LAST);

    // blink only runs in manual-off; idles lit so flashing starts on
    blink_cnt_d = '0;
    blink_d     = 1'b1;
    if (sw_q) begin
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
      blink_d     = blink_q ^ (blink_cnt_q == BLINK_LAST);
    end

    // lamps
    green_d  = 1'b0;
    yellow_d = 1'b0;
    arrow_d  = 3'b000;
    if (sw_q) begin
      yellow_d = blink_q;
    end else begin
      case (phase_q)
        2'b01:   begin green_d = 1'b1; arrow_d = 3'b100; end
        2'b10:   begin green_d = 1'b1; arrow_d = 3'b010; end
        2'b11:   begin green_d = 1'b1; arrow_d = 3'b001; end
        default: yellow_d = 1'b1;
      endcase
    end

    // display uses next-state digits so a finished conversion shows the same edge it lands
    seg_d = 7'h00;
    dig_d = 2'b00;
    if (!sw_q) begin
      if (!dig_sel_d) begin
        seg_d = seg_enc(ones_d);
        dig_d = 2'b01;
      end else if (tens_d != 4'd0) begin
        seg_d = seg_enc(tens_d);
        dig_d = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 2'b00;
      count_q     <= '0;
      sw_q        <= 1'b0;
      green_q     <= 1'b0;
      yellow_q    <= 1'b0;
      arrow_q     <= 3'b000;
      seg_q       <= 7'h00;
      dig_q       <= 2'b00;
      sat_q       <= 1'b0;
      sr_q        <= '0;
      shift_cnt_q <= 3'd0;
      conv_src_q  <= '0;
      conv_sat_q  <= 1'b0;
      last_conv_q <= '0;
      pending_q   <= 1'b0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      scan_cnt_q  <= '0;
      dig_sel_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      sw_q        <= sw_d;
      green_q     <= green_d;
      yellow_q    <= yellow_d;
      arrow_q     <= arrow_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      sat_q       <= sat_d;
      sr_q        <= sr_d;
      shift_cnt_q <= shift_cnt_d;
      conv_src_q  <= conv_src_d;
      conv_sat_q  <= conv_sat_d;
      last_conv_q <= last_conv_d;
      pending_q   <= pending_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_sel_q   <= dig_sel_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign lamp_green  = green_q;
  assign lamp_yellow = yellow_q;
  assign arrow       = arrow_q;
  assign seg         = seg_q;
  assign dig         = dig_q;
  assign sat         = sat_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_traffic_display_driver.sv
// tb/tb_traffic_display_driver.sv - directed bench for traffic_display_driver (SCAN_DIV=4, BLINK_DIV=8)
module tb_traffic_display_driver;

  logic        clk;
  logic        reset;
  logic [1:0]  phase;
  logic [31:0] count;
  logic        switch;
  logic        lamp_green;
  logic        lamp_yellow;
  logic [2:0]  arrow;
  logic [6:0]  seg;
  logic [1:0]  dig;
  logic        sat;
  logic        busy;

  int errors = 0;
  int checks = 0;

  traffic_display_driver #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .reset(reset), .phase(phase), .count(count), .switch(switch),
    .lamp_green(lamp_green), .lamp_yellow(lamp_yellow), .arrow(arrow),
    .seg(seg), .dig(dig), .sat(sat), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; phase = 2'b10; count = 32'd0; switch = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_lamps", {29'd0, lamp_green, lamp_yellow, arrow}, 32'd0);
    check("rst_disp",  {22'd0, seg, dig, sat, busy}, 32'd0);
    #10;
    count = 32'd15; reset = 1'b1;

    // edges counted from reset release; slot = ones when (edge/4) is even
    step(1);   // 1
    check("e1_lamps", {30'd0, lamp_green, lamp_yellow}, 32'b01);
    check("e1_disp",  {23'd0, seg, dig}, {23'd0, 7'h3F, 2'b01});
    check("e1_busy",  {31'd0, busy}, 32'd0);
    step(1);   // 2
    check("fwd_lamps", {27'd0, lamp_green, lamp_yellow, arrow}, {27'd0, 1'b1, 1'b0, 3'b010});
    check("busy_start", {31'd0, busy}, 32'd1);
    step(8);   // 10
    check("busy_last", {31'd0, busy}, 32'd1);
    step(1);   // 11
    check("busy_end", {31'd0, busy}, 32'd0);
    check("d15_ones", {22'd0, seg, dig, sat}, {22'd0, 7'h6D, 2'b01, 1'b0});
    step(1);   // 12
    check("d15_tens", {23'd0, seg, dig}, {23'd0, 7'h06, 2'b10});
    step(3);   // 15
    check("d15_tens_hold", {30'd0, dig}, 32'b10);
    step(1);   // 16
    check("d15_ones2", {23'd0, seg, dig}, {23'd0, 7'h6D, 2'b01});

    phase = 2'b11;
    step(1);   // 17
    check("right_lat", {29'd0, arrow}, 32'b010);
    step(1);   // 18
    check("right", {27'd0, lamp_green, lamp_yellow, arrow}, {27'd0, 1'b1, 1'b0, 3'b001});
    phase = 2'b01;
    step(2);   // 20
    check("left", {27'd0, lamp_green, lamp_yellow, arrow}, {27'd0, 1'b1, 1'b0, 3'b100});
    phase = 2'b00;
    step(2);   // 22
    check("off", {27'd0, lamp_green, lamp_yellow, arrow}, {27'd0, 1'b0, 1'b1, 3'b000});
    phase = 2'b10;
    step(2);   // 24
    check("fwd_again", {27'd0, lamp_green, lamp_yellow, arrow}, {27'd0, 1'b1, 1'b0, 3'b010});

    count = 32'd250;
    step(10);  // 34
    check("sat_pre", {21'd0, seg, dig, sat, busy}, {21'd0, 7'h6D, 2'b01, 1'b0, 1'b1});
    step(1);   // 35
    check("sat_ones", {21'd0, seg, dig, sat, busy}, {21'd0, 7'h6F, 2'b01, 1'b1, 1'b0});
    step(1);   // 36
    check("sat_tens", {23'd0, seg, dig}, {23'd0, 7'h6F, 2'b10});

    count = 32'd7;
    step(10);  // 46
    check("d7_pre", {22'd0, seg, dig, sat}, {22'd0, 7'h6F, 2'b10, 1'b1});
    step(1);   // 47
    check("d7_blank", {22'd0, seg, dig, sat}, {22'd0, 7'h00, 2'b00, 1'b0});
    step(1);   // 48
    check("d7_ones", {23'd0, seg, dig}, {23'd0, 7'h07, 2'b01});

    count = 32'd12;
    step(4);   // 52: second SHIFT cycle
    count = 32'd11;
    step(7);   // 59
    check("d12_busy", {31'd0, busy}, 32'd0);
    check("d12_ones", {23'd0, seg, dig}, {23'd0, 7'h5B, 2'b01});
    for (int k = 60; k <= 68; k++) begin
      step(1);
      check("d12_hold_busy", {31'd0, busy}, 32'd1);
      check("d12_hold_seg", {25'd0, seg}, {25'd0, (dig == 2'b01) ? 7'h5B : 7'h06});
    end
    step(1);   // 69
    check("d11_done", {22'd0, seg, dig, busy}, {22'd0, 7'h06, 2'b10, 1'b0});
    step(3);   // 72
    check("d11_ones", {23'd0, seg, dig}, {23'd0, 7'h06, 2'b01});

    switch = 1'b1;
    step(1);   // 73
    check("sw_lat", {30'd0, lamp_green, lamp_yellow}, 32'b10);
    for (int k = 74; k <= 89; k++) begin
      step(1);
      check("blink_yellow", {31'd0, lamp_yellow}, {31'd0, (k < 82)});
      check("blink_forced", {20'd0, lamp_green, arrow, seg, dig}, 32'd0);
    end
    step(1);   // 90
    check("blink_relit", {31'd0, lamp_yellow}, 32'd1);
    switch = 1'b0;
    step(1);   // 91
    check("sw_fall_lat", {31'd0, lamp_green}, 32'd0);
    step(1);   // 92
    check("sw_resume", {18'd0, lamp_green, lamp_yellow, arrow, seg, dig}, {18'd0, 1'b1, 1'b0, 3'b010, 7'h06, 2'b10});

    count = 32'd3;
    step(4);   // 96: mid-SHIFT
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst", {16'd0, lamp_green, lamp_yellow, arrow, seg, dig, sat, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(10);  // 10 after release
    check("rst_conv_busy", {22'd0, seg, dig, busy}, {22'd0, 7'h3F, 2'b01, 1'b1});
    step(1);   // 11
    check("rst_conv_done", {22'd0, seg, dig, busy}, {22'd0, 7'h4F, 2'b01, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
